// File: rtl/data_mem_responder_if.sv
// Bus between the MEM pipeline stage (master) and the data-memory responder (slave).
interface data_mem_responder_if #(
    parameter int DATA_W = 32
);
    logic              MemRead_MEM;
    logic              MemWrite_MEM;
    logic [31:0]       ALU_result_MEM;
    logic [DATA_W-1:0] Read_Data_2_MEM;
    logic [DATA_W-1:0] Read_data_MEM;
    logic              memStall;
    logic              memDone;
    logic              memError;

    modport master (
        output MemRead_MEM, MemWrite_MEM, ALU_result_MEM, Read_Data_2_MEM,
        input  Read_data_MEM, memStall, memDone, memError
    );

    modport slave (
        input  MemRead_MEM, MemWrite_MEM, ALU_result_MEM, Read_Data_2_MEM,
        output Read_data_MEM, memStall, memDone, memError
    );
endinterface

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: word array served after WAIT_CYCLES wait states.
// Optional macro MEM_MISALIGN_CHECK_EN turns misaligned accesses into error pulses.
module data_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              mis_q, mis_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic req;
    logic accept;
    logic enter_resp;
    logic mem_we;
    logic mis_in;
    logic unused_addr;

    assign req    = bus.MemRead_MEM | bus.MemWrite_MEM;
    assign accept = (state_q == S_IDLE) && req;

`ifdef MEM_MISALIGN_CHECK_EN
    assign mis_in = (bus.ALU_result_MEM[1:0] != 2'b00);
`else
    assign mis_in = 1'b0;
`endif

    // Upper address bits wrap away; byte-offset bits only matter with the check enabled.
    assign unused_addr = ^{bus.ALU_result_MEM[31:ADDR_W+2], bus.ALU_result_MEM[1:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        mis_d      = mis_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    rd_d    = bus.MemRead_MEM;
                    wr_d    = bus.MemWrite_MEM;
                    mis_d   = mis_in;
                    idx_d   = bus.ALU_result_MEM[ADDR_W+1:2];
                    wdata_d = bus.Read_Data_2_MEM;
                    cnt_d   = WAIT_LD;
                    if (WAIT_LD == 4'd0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                    cnt_d      = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The *_d access fields already hold the transaction being completed on this edge.
    always_comb begin
        rdata_d = rdata_q;
        if (enter_resp && rd_d && !mis_d) begin
            rdata_d = mem[idx_d];
        end
        done_d = enter_resp;
        err_d  = enter_resp & mis_d;
        mem_we = rst_n & enter_resp & wr_d & ~mis_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_d] <= wdata_d;
        end
    end

    // Stall rises combinationally on an IDLE request so the pipeline freezes that same cycle.
    assign bus.memStall      = rst_n & (accept | (state_q == S_WAIT));
    assign bus.memDone       = done_q;
    assign bus.memError      = err_q;
    assign bus.Read_data_MEM = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: two instances (2 and 0 wait states) checked
// every cycle against a transaction-level model, plus directed literal scenarios.
module tb_data_mem_responder;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NL = 2;

    logic clk = 1'b0;
    logic rst_n;

    logic          rd    [NL];
    logic          wr    [NL];
    logic [31:0]   addr  [NL];
    logic [DW-1:0] wdata [NL];

    logic [DW-1:0] rdata_o [NL];
    logic          stall_o [NL];
    logic          done_o  [NL];
    logic          err_o   [NL];

    data_mem_responder_if #(.DATA_W(DW)) bus0 ();
    data_mem_responder_if #(.DATA_W(DW)) bus1 ();

    assign bus0.MemRead_MEM     = rd[0];
    assign bus0.MemWrite_MEM    = wr[0];
    assign bus0.ALU_result_MEM  = addr[0];
    assign bus0.Read_Data_2_MEM = wdata[0];
    assign bus1.MemRead_MEM     = rd[1];
    assign bus1.MemWrite_MEM    = wr[1];
    assign bus1.ALU_result_MEM  = addr[1];
    assign bus1.Read_Data_2_MEM = wdata[1];

    assign rdata_o[0] = bus0.Read_data_MEM;
    assign stall_o[0] = bus0.memStall;
    assign done_o[0]  = bus0.memDone;
    assign err_o[0]   = bus0.memError;
    assign rdata_o[1] = bus1.Read_data_MEM;
    assign stall_o[1] = bus1.memStall;
    assign done_o[1]  = bus1.memDone;
    assign err_o[1]   = bus1.memError;

    data_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    data_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(0)) dut_w0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: ph = cycles elapsed since the accept edge (0 = no access in flight).
    int            ph      [NL];
    logic          m_rd    [NL];
    logic          m_wr    [NL];
    logic          m_mis   [NL];
    logic [AW-1:0] m_idx   [NL];
    logic [DW-1:0] m_data  [NL];
    logic [DW-1:0] m_rdata [NL];
    bit            m_rknown[NL];
    logic [DW-1:0] mmem    [NL][256];
    bit            mknown  [NL][256];

    function automatic int wc_of(input int l);
        return (l == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        bit req, es, ed;
        int w, prev;
        for (int l = 0; l < NL; l++) begin
            w   = wc_of(l);
            req = rd[l] | wr[l];
            if (!rst_n) begin
                es          = 1'b0;
                ed          = 1'b0;
                ph[l]       = 0;
                m_mis[l]    = 1'b0;
                m_rdata[l]  = '0;
                m_rknown[l] = 1'b1;
            end else begin
                es = (ph[l] == 0 && req) || (ph[l] >= 1 && ph[l] <= w);
                ed = (ph[l] == w + 1);
            end
            chk($sformatf("stall_l%0d", l), stall_o[l], es);
            chk($sformatf("done_l%0d", l), done_o[l], ed);
            chk($sformatf("err_l%0d", l), err_o[l], ed && m_mis[l]);
            if (m_rknown[l]) chk($sformatf("rdata_l%0d", l), rdata_o[l], m_rdata[l]);
            if (rst_n) begin
                prev = ph[l];
                if (ph[l] == w + 1) ph[l] = 0;
                else if (ph[l] > 0) ph[l] = ph[l] + 1;
                else if (req) begin
                    m_rd[l]   = rd[l];
                    m_wr[l]   = wr[l];
                    m_idx[l]  = addr[l][AW+1:2];
                    m_data[l] = wdata[l];
`ifdef MEM_MISALIGN_CHECK_EN
                    m_mis[l]  = (addr[l][1:0] != 2'b00);
`else
                    m_mis[l]  = 1'b0;
`endif
                    ph[l] = 1;
                end
                if (ph[l] == w + 1 && prev != w + 1 && !m_mis[l]) begin
                    if (m_rd[l]) begin
                        m_rdata[l]  = mmem[l][m_idx[l]];
                        m_rknown[l] = mknown[l][m_idx[l]];
                    end
                    if (m_wr[l]) begin
                        mmem[l][m_idx[l]]   = m_data[l];
                        mknown[l][m_idx[l]] = 1'b1;
                    end
                end
            end
        end
    end

    // Present a request, hold it until memDone, then drop it. Called and returns at posedge+1.
    task automatic access(input int l, input bit r, input bit w, input logic [31:0] a,
                          input logic [DW-1:0] d, output int stall_cnt, output bit err_at,
                          output logic [DW-1:0] rdat_at);
        bit got;
        rd[l] = r; wr[l] = w; addr[l] = a; wdata[l] = d;
        stall_cnt = 0; got = 1'b0; err_at = 1'b0; rdat_at = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (stall_o[l]) stall_cnt++;
            if (done_o[l]) begin
                got     = 1'b1;
                err_at  = err_o[l];
                rdat_at = rdata_o[l];
            end
            @(posedge clk);
            #1;
            if (got) break;
        end
        rd[l] = 1'b0; wr[l] = 1'b0;
        chk($sformatf("done_timeout_l%0d", l), got, 1'b1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int sc;
        bit e;
        logic [DW-1:0] rv;
        logic [31:0] a;
        int l, kind, gap;

        rst_n = 1'b0;
        for (int i = 0; i < NL; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
            ph[i] = 0; m_rknown[i] = 1'b1; m_rdata[i] = '0; m_mis[i] = 1'b0;
            m_rd[i] = 1'b0; m_wr[i] = 1'b0; m_idx[i] = '0; m_data[i] = '0;
            for (int j = 0; j < 256; j++) begin
                mknown[i][j] = 1'b0;
                mmem[i][j]   = '0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", rdata_o[0], 32'h0);
        chk("reset_stall", stall_o[0], 1'b0);
        chk("reset_done", done_o[0], 1'b0);
        chk("reset_err", err_o[0], 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two wait states: 3 stall cycles per access
        access(0, 1'b0, 1'b1, 32'h04, 32'h12345678, sc, e, rv);
        chk("t1_write_stall_cycles", sc, 3);
        access(0, 1'b1, 1'b0, 32'h04, 32'h0, sc, e, rv);
        chk("t1_read_stall_cycles", sc, 3);
        chk("t1_read_data", rv, 32'h12345678);

        // Zero wait states: 1 stall cycle, data with memDone next cycle
        access(1, 1'b0, 1'b1, 32'h04, 32'h0BADF00D, sc, e, rv);
        access(1, 1'b1, 1'b0, 32'h04, 32'h0, sc, e, rv);
        chk("t2_stall_cycles", sc, 1);
        chk("t2_read_data", rv, 32'h0BADF00D);

        // Reset during WAIT aborts the pending write
        access(0, 1'b0, 1'b1, 32'h10, 32'hA5A5A5A5, sc, e, rv);
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'h0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t3_abort_stall", stall_o[0], 1'b0);
        chk("t3_abort_done", done_o[0], 1'b0);
        chk("t3_abort_rdata", rdata_o[0], 32'h0);
        @(posedge clk);
        #1;
        wr[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, sc, e, rv);
        chk("t3_survived_data", rv, 32'hA5A5A5A5);

        // Address wrap modulo 256 words
        access(0, 1'b0, 1'b1, 32'h400, 32'hCAFEF00D, sc, e, rv);
        access(0, 1'b1, 1'b0, 32'h000, 32'h0, sc, e, rv);
        chk("t4_wrap_data", rv, 32'hCAFEF00D);

        // Simultaneous read+write returns pre-write contents
        access(0, 1'b0, 1'b1, 32'h20, 32'h11111111, sc, e, rv);
        access(0, 1'b1, 1'b1, 32'h20, 32'h22222222, sc, e, rv);
        chk("t5_rw_old_data", rv, 32'h11111111);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, sc, e, rv);
        chk("t5_new_data", rv, 32'h22222222);

        // Misaligned store to byte 0x06 (word 1)
        access(0, 1'b0, 1'b1, 32'h06, 32'h0000BEEF, sc, e, rv);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("t6_err", e, 1'b1);
        access(0, 1'b1, 1'b0, 32'h04, 32'h0, sc, e, rv);
        chk("t6_word1", rv, 32'h12345678);
`else
        chk("t6_err", e, 1'b0);
        access(0, 1'b1, 1'b0, 32'h04, 32'h0, sc, e, rv);
        chk("t6_word1", rv, 32'h0000BEEF);
`endif

        // Random traffic over a small word window with wrap bits and occasional misalignment
        for (int i = 0; i < 300; i++) begin
            l    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 2));
            a    = 32'($urandom_range(0, 15)) << 2;
            a    = a | (32'($urandom_range(0, 3)) << 10);
            if (($urandom % 4) == 0) a = a | 32'($urandom_range(1, 3));
            access(l, kind != 1, kind != 0, a, $urandom, sc, e, rv);
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
